// File: rtl/telemetry_frame_tx.sv
// telemetry_frame_tx: latches a sensor snapshot and sends it as a framed UART 8N1 byte stream.
// Define TELEM_CHECKSUM_EN to append a two's-complement checksum byte, making six bytes per frame.
module telemetry_frame_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] moisture_i,
    input  logic [7:0] light_i,
    input  logic [7:0] temp_i,
    input  logic [7:0] act_i,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       frame_done
);
`ifdef TELEM_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic          done_q, done_d;
    logic [7:0]    moist_q, light_q, temp_q, act_q;
    logic [7:0]    cur_byte;
    logic          bit_end, cap;
`ifdef TELEM_CHECKSUM_EN
    logic [7:0]    chk_q;
`endif

    assign bit_end    = baud_q == CW'(CLKS_PER_BIT - 1);
    assign cap        = (state_q == IDLE) && in_valid;
    assign in_ready   = state_q == IDLE;
    assign tx_busy    = state_q != IDLE;
    assign frame_done = done_q;
    assign tx = (state_q == START) ? 1'b0 : (state_q == DATA) ? cur_byte[bit_q] : 1'b1;

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_q)
            3'd1: cur_byte = moist_q;
            3'd2: cur_byte = light_q;
            3'd3: cur_byte = temp_q;
            3'd4: cur_byte = act_q;
`ifdef TELEM_CHECKSUM_EN
            3'd5: cur_byte = chk_q;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (in_valid) begin
                    state_d = START;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = 3'd0;
            end
            DATA: if (bit_end) begin
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            default: if (bit_end) begin
                // Last stop bit: the IDLE entry cycle carries the frame_done pulse.
                state_d = (byte_q == 3'(NBYTES - 1)) ? IDLE : START;
                done_d  = byte_q == 3'(NBYTES - 1);
                byte_d  = (byte_q == 3'(NBYTES - 1)) ? byte_q : byte_q + 3'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            moist_q <= '0;
            light_q <= '0;
            temp_q  <= '0;
            act_q   <= '0;
`ifdef TELEM_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else if (cap) begin
            moist_q <= moisture_i;
            light_q <= light_i;
            temp_q  <= temp_i;
            act_q   <= act_i;
`ifdef TELEM_CHECKSUM_EN
            chk_q   <= 8'd0 - (SYNC_BYTE + moisture_i + light_i + temp_i + act_i);
`endif
        end
    end
endmodule

// File: tb/tb_telemetry_frame_tx.sv
// tb_telemetry_frame_tx: random and directed frames; a UART receiver and a frame_done
// monitor pop expectations pushed by the stimulus at capture time.
module tb_telemetry_frame_tx;
    localparam int CPB = 4;
`ifdef TELEM_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] moisture_i = '0, light_i = '0, temp_i = '0, act_i = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, tx, tx_busy, frame_done;

    int         cyc = 0;
    int         rst_cnt = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_bytes[$];
    int         exp_done[$];

    telemetry_frame_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .moisture_i(moisture_i), .light_i(light_i),
        .temp_i(temp_i), .act_i(act_i), .in_valid(in_valid), .in_ready(in_ready),
        .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_cnt <= rst_cnt + 1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_frame(input logic [7:0] m, l, t, a);
        int sum;
        sum = 'hA5 + m + l + t + a;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(m);
        exp_bytes.push_back(l);
        exp_bytes.push_back(t);
        exp_bytes.push_back(a);
        if (NB == 6) exp_bytes.push_back(8'((256 - sum % 256) % 256));
    endtask

    // Called at a negedge; returns at the negedge just after the capturing edge.
    task automatic send(input logic [7:0] m, l, t, a, input bit hold, output int cap);
        int n;
        n = 0;
        moisture_i = m; light_i = l; temp_i = t; act_i = a;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("capture_timeout", 0, 1);
            cap = -1;
        end else begin
            push_frame(m, l, t, a);
            @(negedge clk);
            cap = cyc;
            exp_done.push_back(cyc + NB * 10 * CPB);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    initial begin : rx
        logic [9:0] bits;
        int         rc;
        bit         abort;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                rc = rst_cnt;
                abort = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    repeat (k == 0 ? 2 : CPB) @(negedge clk);
                    if (rst_cnt != rc || rst) abort = 1'b1;
                    bits[k] = tx;
                end
                if (!abort) begin
                    check("start_bit", int'(bits[0]), 0);
                    check("stop_bit", int'(bits[9]), 1);
                    if (exp_bytes.size() == 0) check("unexpected_byte", int'(bits[8:1]), -1);
                    else check("data_byte", int'(bits[8:1]), int'(exp_bytes.pop_front()));
                end
            end
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                if (exp_done.size() == 0) check("unexpected_frame_done", cyc, -1);
                else check("frame_done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    initial begin : stim
        int  c1, c2, n;
        bit  ok;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_tx_busy", int'(tx_busy), 0);
        check("reset_frame_done", int'(frame_done), 0);
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            ok &= (tx === 1'b1);
        end
        check("idle_tx_high", int'(ok), 1);

        send(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, c1);
        check("busy_after_capture", int'(tx_busy), 1);
        check("tx_start_low", int'(tx), 0);

        // Field changes and an in_valid pulse during byte 2 must not disturb the frame.
        repeat (2 * 10 * CPB + 5) @(negedge clk);
        moisture_i = 8'hFF; light_i = 8'hFF; temp_i = 8'hFF; act_i = 8'hFF;
        in_valid = 1'b1;
        check("in_ready_busy", int'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;

        // Held in_valid: second capture occurs on the edge ending the frame_done cycle.
        send(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, c1);
        send(8'hC3, 8'h3C, 8'h81, 8'h7E, 1'b0, c2);
        check("back_to_back_capture", c2, c1 + NB * 10 * CPB + 1);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), c1);
        end
        in_valid = 1'b0;

        // Reset during data of byte 3: frame abandoned, no frame_done.
        n = 0;
        while (tx_busy && n < 2000) begin @(negedge clk); n++; end
        send(8'h5A, 8'h6B, 8'h7C, 8'h8D, 1'b0, c1);
        repeat (3 * 10 * CPB + CPB + 3 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_bytes.delete();
        exp_done.delete();
        check("midreset_tx", int'(tx), 1);
        check("midreset_busy", int'(tx_busy), 0);
        check("midreset_frame_done", int'(frame_done), 0);
        repeat (NB * 10 * CPB) @(negedge clk);
        send(8'h9E, 8'h11, 8'hE0, 8'h2F, 1'b0, c1);

        n = 0;
        while ((exp_bytes.size() != 0 || exp_done.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_bytes", exp_bytes.size(), 0);
        check("drain_frame_done", exp_done.size(), 0);
        repeat (20) @(negedge clk);
        check("final_idle_tx", int'(tx), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
